// File: rtl/pl_trace_dumper.sv
// End-of-run trace unit: halts the CPU on a stop-PC match or cycle timeout, then streams PC, instr and the register file.
// Optional macro TRACE_CYCLES_EN appends the frozen cycle count as a final word.
module pl_trace_dumper #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int NREG       = 32,
    parameter int RSELW      = 5,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             pc_valid_i,
    input  logic [AW-1:0]    pc_i,
    input  logic [DW-1:0]    instr_i,
    input  logic [AW-1:0]    stop_pc_i,
    output logic [RSELW-1:0] reg_sel_o,
    input  logic [DW-1:0]    reg_data_i,
    output logic             dump_valid_o,
    output logic [DW-1:0]    dump_data_o,
    output logic [7:0]       dump_idx_o,
    input  logic             dump_ready_i,
    output logic             halt_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CW-1:0]    cycle_cnt_o,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_HDR   = 3'd1,
        S_FETCH = 3'd2,
        S_LOAD  = 3'd3,
        S_WAIT  = 3'd4,
        S_TAIL  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    if (NREG > 2**RSELW) begin : g_bad_nreg
        $error("pl_trace_dumper: NREG exceeds 2**RSELW");
    end
    if (NREG + 3 > 256) begin : g_bad_idx
        $error("pl_trace_dumper: dump index does not fit 8 bits");
    end
    if (MAX_CYCLES < 1 || MAX_CYCLES > 2**CW - 1) begin : g_bad_max
        $error("pl_trace_dumper: MAX_CYCLES out of range");
    end

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [AW-1:0]     r_last_pc;
    logic [DW-1:0]     r_last_instr;
    logic [DW-1:0]     r_instr;
    logic [DW-1:0]     r_data;
    logic [7:0]        r_idx;
    logic [RSELW-1:0]  r_reg;
    logic              r_timeout;

    logic              w_match;
    logic              w_tmo;
    logic              w_trig;
    logic              w_accept;
    logic              w_last_reg;
    logic [AW-1:0]     w_lat_pc;
    logic [DW-1:0]     w_lat_instr;

    assign w_match     = pc_valid_i && (pc_i == stop_pc_i);
    assign w_tmo       = (r_cnt == CW'(MAX_CYCLES - 1));
    assign w_trig      = (r_state == S_RUN) && enable_i && (w_match || w_tmo);
    // Valid/ready: a word transfers on a rising edge where dump_valid_o && dump_ready_i;
    // until then valid stays high and data/index are held unchanged.
    assign w_accept    = dump_valid_o && dump_ready_i;
    assign w_last_reg  = (r_reg == RSELW'(NREG - 1));
    assign w_lat_pc    = pc_valid_i ? pc_i : r_last_pc;
    assign w_lat_instr = pc_valid_i ? instr_i : r_last_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN:   if (w_trig) w_next = S_HDR;
            S_HDR:   if (w_accept && r_idx == 8'd1) w_next = S_FETCH;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_WAIT;
            S_WAIT: begin
                if (w_accept) begin
                    if (!w_last_reg) begin
                        w_next = S_FETCH;
                    end else begin
`ifdef TRACE_CYCLES_EN
                        w_next = S_TAIL;
`else
                        w_next = S_DONE;
`endif
                    end
                end
            end
            S_TAIL:  if (w_accept) w_next = S_DONE;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_RUN;
        endcase
    end

    always_comb begin
        halt_o       = (r_state != S_RUN);
        done_o       = (r_state == S_DONE);
        dump_valid_o = (r_state == S_HDR) || (r_state == S_WAIT) || (r_state == S_TAIL);
        reg_sel_o    = '0;
        if (r_state == S_FETCH || r_state == S_LOAD || r_state == S_WAIT) begin
            reg_sel_o = r_reg;
        end
        dbg_state_o  = r_state;
    end

    assign dump_data_o = r_data;
    assign dump_idx_o  = r_idx;
    assign timeout_o   = r_timeout;
    assign cycle_cnt_o = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_last_pc    <= '0;
            r_last_instr <= '0;
            r_instr      <= '0;
            r_data       <= '0;
            r_idx        <= '0;
            r_reg        <= '0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (pc_valid_i) begin
                        r_last_pc    <= pc_i;
                        r_last_instr <= instr_i;
                    end
                    if (w_trig) begin
                        // Match wins over a coincident timeout; the counter freezes from here on.
                        r_timeout <= !w_match;
                        r_instr   <= w_lat_instr;
                        r_data    <= DW'(w_lat_pc);
                        r_idx     <= 8'd0;
                    end else if (enable_i && r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HDR: begin
                    if (w_accept && r_idx == 8'd0) begin
                        r_data <= r_instr;
                        r_idx  <= 8'd1;
                    end else if (w_accept) begin
                        r_reg <= '0;
                    end
                end
                S_LOAD: begin
                    r_data <= (r_reg == '0) ? '0 : reg_data_i;
                    r_idx  <= 8'(r_reg) + 8'd2;
                end
                S_WAIT: begin
                    if (w_accept && !w_last_reg) begin
                        r_reg <= r_reg + 1'b1;
                    end
`ifdef TRACE_CYCLES_EN
                    if (w_accept && w_last_reg) begin
                        r_data <= DW'(r_cnt);
                        r_idx  <= 8'(NREG + 2);
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pl_trace_dumper.sv
// Bench for pl_trace_dumper: randomized CPU traffic and sink backpressure against a queue-based dump model.
module tb_pl_trace_dumper;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NREG  = 32;
  localparam int RSELW = 5;
  localparam int CW    = 16;
  localparam int MAXC  = 20;
`ifdef TRACE_CYCLES_EN
  localparam int NWORDS = NREG + 3;
`else
  localparam int NWORDS = NREG + 2;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable_i = 1'b0;
  logic             pc_valid_i = 1'b0;
  logic [AW-1:0]    pc_i = '0;
  logic [DW-1:0]    instr_i = '0;
  logic [AW-1:0]    stop_pc_i = '0;
  logic [RSELW-1:0] reg_sel_o;
  logic [DW-1:0]    reg_data_i;
  logic             dump_valid_o;
  logic [DW-1:0]    dump_data_o;
  logic [7:0]       dump_idx_o;
  logic             dump_ready_i = 1'b0;
  logic             halt_o;
  logic             done_o;
  logic             timeout_o;
  logic [CW-1:0]    cycle_cnt_o;
  logic [2:0]       dbg_state_o;

  logic [DW-1:0]    rf [NREG];
  assign reg_data_i = rf[reg_sel_o];

  pl_trace_dumper #(
    .AW(AW), .DW(DW), .NREG(NREG), .RSELW(RSELW), .CW(CW), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .pc_valid_i(pc_valid_i),
    .pc_i(pc_i), .instr_i(instr_i), .stop_pc_i(stop_pc_i),
    .reg_sel_o(reg_sel_o), .reg_data_i(reg_data_i),
    .dump_valid_o(dump_valid_o), .dump_data_o(dump_data_o), .dump_idx_o(dump_idx_o),
    .dump_ready_i(dump_ready_i), .halt_o(halt_o), .done_o(done_o),
    .timeout_o(timeout_o), .cycle_cnt_o(cycle_cnt_o), .dbg_state_o(dbg_state_o)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] exp_q[$];

  // reference model state
  logic [CW-1:0] cnt_m;
  logic [AW-1:0] last_pc_m;
  logic [DW-1:0] last_instr_m;
  logic          exp_tmo;
  logic [AW-1:0] trig_pc;
  logic [DW-1:0] trig_instr;
  logic [CW-1:0] trig_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"},   64'(reg_sel_o), 64'd0);
    chk({tag, "_valid"}, 64'(dump_valid_o), 64'd0);
    chk({tag, "_data"},  64'(dump_data_o), 64'd0);
    chk({tag, "_idx"},   64'(dump_idx_o), 64'd0);
    chk({tag, "_halt"},  64'(halt_o), 64'd0);
    chk({tag, "_done"},  64'(done_o), 64'd0);
    chk({tag, "_tmo"},   64'(timeout_o), 64'd0);
    chk({tag, "_cnt"},   64'(cycle_cnt_o), 64'd0);
  endtask

  task automatic fill_rf();
    for (int i = 0; i < NREG; i++) rf[i] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable_i = 1'b0;
    pc_valid_i = 1'b0;
    dump_ready_i = 1'b0;
    #1;
    chk_all_zero("in_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("after_reset");
    cnt_m = '0;
    last_pc_m = '0;
    last_instr_m = '0;
    exp_q.delete();
  endtask

  // mode 0: always valid/enabled; 1: random valid, no valid on the timeout cycle; 2: random valid and enable
  task automatic run_cpu(input logic [AW-1:0] stop, input logic [AW-1:0] start_pc, input int mode);
    logic [AW-1:0] pc;
    logic [DW-1:0] ins;
    logic en, v, match;
    bit fired;
    pc = start_pc;
    fired = 0;
    for (int k = 0; k < 300 && !fired; k++) begin
      chk("run_cnt", 64'(cycle_cnt_o), 64'(cnt_m));
      chk("run_halt", 64'(halt_o), 64'd0);
      en  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      v   = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (mode == 1 && cnt_m == CW'(MAXC - 1)) v = 1'b0;
      ins = $urandom;
      enable_i = en;
      pc_valid_i = v;
      pc_i = pc;
      instr_i = ins;
      stop_pc_i = stop;
      match = v && (pc == stop);
      if (en && (match || cnt_m == CW'(MAXC - 1))) begin
        fired = 1;
        exp_tmo = !match;
        trig_pc = v ? pc : last_pc_m;
        trig_instr = v ? ins : last_instr_m;
        trig_cnt = cnt_m;
      end else if (en && cnt_m != '1) begin
        cnt_m = cnt_m + 1'b1;
      end
      if (v) begin
        last_pc_m = pc;
        last_instr_m = ins;
        pc = pc + 32'd4;
      end
      @(negedge clk);
    end
    if (!fired) chk("trigger_budget", 64'd0, 64'd1);
    chk("trig_halt", 64'(halt_o), 64'd1);
    chk("trig_tmo", 64'(timeout_o), 64'(exp_tmo));
    chk("trig_cnt", 64'(cycle_cnt_o), 64'(trig_cnt));
    chk("trig_valid", 64'(dump_valid_o), 64'd1);
    chk("trig_idx0", 64'(dump_idx_o), 64'd0);
    exp_q.delete();
    exp_q.push_back(DW'(trig_pc));
    exp_q.push_back(trig_instr);
    exp_q.push_back('0);
    for (int r = 1; r < NREG; r++) exp_q.push_back(rf[r]);
`ifdef TRACE_CYCLES_EN
    exp_q.push_back(DW'(trig_cnt));
`endif
  endtask

  // rmode 0: always ready; 1: pattern 1,0,0,1; 2: random. abort_idx >= 0 resets when that word shows.
  task automatic run_dump(input int rmode, input int abort_idx);
    int pat[4];
    bit stall, fin;
    logic [DW-1:0] sd;
    logic [7:0] si;
    logic [DW-1:0] ew;
    int nexp;
    pat = '{1, 0, 0, 1};
    stall = 0;
    fin = 0;
    nexp = 0;
    sd = '0;
    si = '0;
    for (int k = 0; k < 1500 && !fin; k++) begin
      pc_i = $urandom;
      stop_pc_i = ($urandom_range(0, 1) != 0) ? pc_i : $urandom;
      pc_valid_i = ($urandom_range(0, 1) != 0);
      enable_i = ($urandom_range(0, 1) != 0);
      instr_i = $urandom;
      if (rmode == 0) dump_ready_i = 1'b1;
      else if (rmode == 1) dump_ready_i = (pat[k % 4] != 0);
      else dump_ready_i = ($urandom_range(0, 1) != 0);
      if (stall) begin
        chk("stall_valid", 64'(dump_valid_o), 64'd1);
        chk("stall_data", 64'(dump_data_o), 64'(sd));
        chk("stall_idx", 64'(dump_idx_o), 64'(si));
      end
      if (done_o) begin
        fin = 1;
        chk("done_words", 64'(nexp), 64'(NWORDS));
        chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
      end else if (abort_idx >= 0 && dump_valid_o && dump_idx_o == 8'(abort_idx)) begin
        fin = 1;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_dump_reset");
      end else begin
        chk("dump_halt", 64'(halt_o), 64'd1);
        chk("dump_cnt_frozen", 64'(cycle_cnt_o), 64'(trig_cnt));
        if (dump_valid_o && dump_ready_i) begin
          chk("word_idx", 64'(dump_idx_o), 64'(nexp));
          if (exp_q.size() == 0) begin
            chk("extra_word", 64'(dump_idx_o), 64'hFFFF);
          end else begin
            ew = exp_q.pop_front();
            chk("word_data", 64'(dump_data_o), 64'(ew));
          end
          nexp++;
        end
      end
      stall = dump_valid_o && !dump_ready_i && !fin;
      sd = dump_data_o;
      si = dump_idx_o;
      if (!fin) @(negedge clk);
    end
    if (!fin) chk("dump_budget", 64'd0, 64'd1);
  endtask

  task automatic post_done();
    for (int k = 0; k < 5; k++) begin
      pc_i = $urandom;
      stop_pc_i = pc_i;
      pc_valid_i = 1'b1;
      enable_i = 1'b1;
      dump_ready_i = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      chk("post_done", 64'(done_o), 64'd1);
      chk("post_halt", 64'(halt_o), 64'd1);
      chk("post_valid", 64'(dump_valid_o), 64'd0);
      chk("post_cnt", 64'(cycle_cnt_o), 64'(trig_cnt));
    end
  endtask

  initial begin
    fill_rf();
    do_reset();

    // stop-address match
    run_cpu(32'h80, 32'h60, 0);
    chk("match_tmo", 64'(timeout_o), 64'd0);
    chk("match_word0", 64'(dump_data_o), 64'h80);
    run_dump(0, -1);
    post_done();

    // timeout with no valid PC on the trigger cycle
    do_reset();
    fill_rf();
    run_cpu(32'hFFFF_FFF0, 32'h1000, 1);
    chk("tmo_flag", 64'(timeout_o), 64'd1);
    chk("tmo_cnt", 64'(cycle_cnt_o), 64'(MAXC - 1));
    run_dump(0, -1);
    post_done();

    // backpressure 1,0,0,1 with gappy enable
    do_reset();
    fill_rf();
    run_cpu(32'h200, 32'h1F0, 2);
    run_dump(1, -1);
    post_done();

    // match and timeout in the same cycle
    do_reset();
    fill_rf();
    run_cpu(32'h80, 32'h34, 0);
    chk("simul_tmo", 64'(timeout_o), 64'd0);
    chk("simul_word0", 64'(dump_data_o), 64'h80);
    chk("simul_cnt", 64'(cycle_cnt_o), 64'(MAXC - 1));
    run_dump(2, -1);
    post_done();

    // reset mid-dump, then a full fresh run
    do_reset();
    fill_rf();
    run_cpu(32'h80, 32'h70, 0);
    run_dump(2, 10);
    do_reset();
    fill_rf();
    run_cpu(32'h90, 32'h80, 2);
    run_dump(2, -1);
    post_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
